// File: rtl/reverb_start_sequencer.sv
// Reverb start sequencer: Avalon-MM register slave that issues a timed start
// pulse to the reverb datapath, then waits for its done level or a timeout.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | nothing in flight; a START write launches a sequence
// PULSE  | out_port high; pulse down-counter running to terminal count
// WAIT   | waiting for done_in; optional timeout down-counter running
module reverb_start_sequencer #(
    parameter int PULSE_W   = 16,
    parameter int TIMEOUT_W = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        done_in,
    output logic        out_port,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_PULSE   = 2'd2;
    localparam logic [1:0] ADDR_TIMEOUT = 2'd3;

    state_t                 state_q;
    state_t                 state_next;

    logic                   irq_en_q;
    logic                   done_q;
    logic                   tmo_q;
    logic [PULSE_W-1:0]     pulse_len_q;
    logic [TIMEOUT_W-1:0]   timeout_q;
    logic [TIMEOUT_W-1:0]   timeout_shadow_q;
    logic [PULSE_W-1:0]     pulse_cnt_q;
    logic [TIMEOUT_W-1:0]   tmo_cnt_q;
    logic                   out_port_q;

    logic                   wr_en;
    logic                   start_req;
    logic                   abort_req;
    logic                   pulse_load;
    logic                   wait_enter;
    logic                   done_set;
    logic                   tmo_set;
    logic                   busy;

    // Upper writedata bits are don't-care for the narrower registers.
    logic                   unused_wdata;
    assign unused_wdata = &{1'b0, writedata};

    assign wr_en     = chipselect & ~write_n;
    assign start_req = wr_en && (address == ADDR_CTRL) && writedata[0];
    assign abort_req = wr_en && (address == ADDR_CTRL) && writedata[2];
    assign busy      = (state_q != ST_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Next-state logic; ABORT overrides everything, done_in beats timeout.
    always_comb begin
        state_next = state_q;
        pulse_load = 1'b0;
        wait_enter = 1'b0;
        done_set   = 1'b0;
        tmo_set    = 1'b0;
        if (abort_req) begin
            state_next = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_req) begin
                        state_next = ST_PULSE;
                        pulse_load = 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (pulse_cnt_q == '0) begin
                        state_next = ST_WAIT;
                        wait_enter = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (done_in) begin
                        state_next = ST_IDLE;
                        done_set   = 1'b1;
                    end else if ((timeout_shadow_q != '0) && (tmo_cnt_q == '0)) begin
                        state_next = ST_IDLE;
                        tmo_set    = 1'b1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Registered start strobe: high exactly while the FSM sits in PULSE.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_port_q <= 1'b0;
        end else begin
            out_port_q <= (state_next == ST_PULSE);
        end
    end

    // Pulse down-counter; loaded with max(len,1)-1 so terminal count ends the pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            pulse_cnt_q <= '0;
        end else if (pulse_load) begin
            pulse_cnt_q <= (pulse_len_q == '0) ? '0 : pulse_len_q - PULSE_W'(1);
        end else if ((state_q == ST_PULSE) && (pulse_cnt_q != '0)) begin
            pulse_cnt_q <= pulse_cnt_q - PULSE_W'(1);
        end
    end

    // Timeout shadow and down-counter; a zero shadow disables expiry entirely.
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_shadow_q <= '0;
            tmo_cnt_q        <= '0;
        end else begin
            if (pulse_load) begin
                timeout_shadow_q <= timeout_q;
            end
            if (wait_enter) begin
                tmo_cnt_q <= (timeout_shadow_q == '0) ? '0
                                                      : timeout_shadow_q - TIMEOUT_W'(1);
            end else if ((state_q == ST_WAIT) && (tmo_cnt_q != '0)) begin
                tmo_cnt_q <= tmo_cnt_q - TIMEOUT_W'(1);
            end
        end
    end

    // Configuration registers written from the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en_q    <= 1'b0;
            pulse_len_q <= PULSE_W'(1);
            timeout_q   <= '0;
        end else if (wr_en) begin
            case (address)
                ADDR_CTRL:    irq_en_q    <= writedata[1];
                ADDR_PULSE:   pulse_len_q <= writedata[PULSE_W-1:0];
                ADDR_TIMEOUT: timeout_q   <= writedata[TIMEOUT_W-1:0];
                default:      ;
            endcase
        end
    end

    // Sticky DONE/TMO flags; a same-edge set wins over write-1-to-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q <= 1'b0;
            tmo_q  <= 1'b0;
        end else begin
            if (done_set) begin
                done_q <= 1'b1;
            end else if (wr_en && (address == ADDR_STATUS) && writedata[1]) begin
                done_q <= 1'b0;
            end
            if (tmo_set) begin
                tmo_q <= 1'b1;
            end else if (wr_en && (address == ADDR_STATUS) && writedata[2]) begin
                tmo_q <= 1'b0;
            end
        end
    end

    // Read mux; pulse bits of CTRL always read back as zero.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL:    readdata = {29'd0, 1'b0, irq_en_q, 1'b0};
            ADDR_STATUS:  readdata = {26'd0, state_q, 1'b0, tmo_q, done_q, busy};
            ADDR_PULSE:   readdata = 32'(pulse_len_q);
            ADDR_TIMEOUT: readdata = 32'(timeout_q);
            default:      readdata = '0;
        endcase
    end

    assign out_port = out_port_q;
    assign irq      = irq_en_q & (done_q | tmo_q);

endmodule

// File: tb/tb_reverb_start_sequencer.sv
// Directed bench for reverb_start_sequencer; inputs driven and outputs
// sampled on the falling clock edge, expected values computed by hand.
module tb_reverb_start_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        done_in;
    logic        out_port;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;
    int hi;

    reverb_start_sequencer #(.PULSE_W(16), .TIMEOUT_W(24)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .done_in    (done_in),
        .out_port   (out_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic read_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check_val(tag, readdata, exp);
    endtask

    // Counts consecutive sampled cycles with out_port high, bounded.
    task automatic count_pulse(output int n);
        n = 0;
        while (out_port && n < 64) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        reset      = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        done_in    = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // reset values
        read_chk("rst_status", 2'd1, 32'h0);
        read_chk("rst_ctrl", 2'd0, 32'h0);
        read_chk("rst_plen", 2'd2, 32'h1);
        read_chk("rst_tmo", 2'd3, 32'h0);
        check_val("rst_out", {31'd0, out_port}, 32'd0);
        check_val("rst_irq", {31'd0, irq}, 32'd0);

        // 4-cycle pulse, no timeout, done 10 cycles after pulse end
        bus_write(2'd2, 32'hFFFF_0004);
        read_chk("plen_trunc", 2'd2, 32'h4);
        bus_write(2'd3, 32'h0);
        bus_write(2'd0, 32'h1);
        read_chk("t1_pulse_st", 2'd1, 32'h11);
        count_pulse(hi);
        check_val("t1_pulse_len", hi, 4);
        read_chk("t1_wait_st", 2'd1, 32'h21);
        repeat (10) @(negedge clk);
        read_chk("t1_still_wait", 2'd1, 32'h21);
        done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
        read_chk("t1_done", 2'd1, 32'h2);
        check_val("t1_irq_off", {31'd0, irq}, 32'd0);
        bus_write(2'd1, 32'h2);
        read_chk("t1_clr", 2'd1, 32'h0);

        // zero pulse length -> 1 cycle, timeout 5 with irq
        bus_write(2'd0, 32'h2);
        bus_write(2'd2, 32'h0);
        bus_write(2'd3, 32'h5);
        bus_write(2'd0, 32'h3);
        count_pulse(hi);
        check_val("t2_pulse_len", hi, 1);
        repeat (4) @(negedge clk);
        read_chk("t2_before_tmo", 2'd1, 32'h21);
        @(negedge clk);
        read_chk("t2_tmo", 2'd1, 32'h4);
        check_val("t2_irq", {31'd0, irq}, 32'd1);
        bus_write(2'd1, 32'h4);
        read_chk("t2_tmo_clr", 2'd1, 32'h0);
        check_val("t2_irq_clr", {31'd0, irq}, 32'd0);

        // done on the same edge as timeout expiry -> DONE wins
        bus_write(2'd2, 32'h1);
        bus_write(2'd3, 32'h3);
        bus_write(2'd0, 32'h3);
        count_pulse(hi);
        check_val("t3_pulse_len", hi, 1);
        repeat (2) @(negedge clk);
        done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
        read_chk("t3_done_wins", 2'd1, 32'h2);
        check_val("t3_irq", {31'd0, irq}, 32'd1);
        bus_write(2'd1, 32'h6);
        read_chk("t3_clr", 2'd1, 32'h0);

        // START during PULSE ignored: total pulse stays 6
        bus_write(2'd2, 32'h6);
        bus_write(2'd3, 32'h0);
        bus_write(2'd0, 32'h1);
        check_val("t4_out_c1", {31'd0, out_port}, 32'd1);
        bus_write(2'd0, 32'h1);
        count_pulse(hi);
        check_val("t4_restart_ign", hi + 1, 6);
        bus_write(2'd0, 32'h4);
        read_chk("t4_abort_wait", 2'd1, 32'h0);

        // ABORT+START in PULSE -> abort wins, out_port low next cycle
        bus_write(2'd2, 32'h8);
        bus_write(2'd0, 32'h1);
        bus_write(2'd0, 32'h1);
        bus_write(2'd0, 32'h5);
        check_val("t5_abort_out", {31'd0, out_port}, 32'd0);
        read_chk("t5_abort_st", 2'd1, 32'h0);
        bus_write(2'd0, 32'h5);
        read_chk("t5_abort_idle", 2'd1, 32'h0);

        // reset mid-WAIT with DONE=1
        bus_write(2'd0, 32'h2);
        bus_write(2'd2, 32'h1);
        bus_write(2'd0, 32'h3);
        count_pulse(hi);
        done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
        bus_write(2'd3, 32'h7);
        bus_write(2'd0, 32'h3);
        count_pulse(hi);
        read_chk("t6_wait_done", 2'd1, 32'h23);
        check_val("t6_irq", {31'd0, irq}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        read_chk("t6_rst_status", 2'd1, 32'h0);
        read_chk("t6_rst_plen", 2'd2, 32'h1);
        read_chk("t6_rst_tmo", 2'd3, 32'h0);
        read_chk("t6_rst_ctrl", 2'd0, 32'h0);
        check_val("t6_rst_irq", {31'd0, irq}, 32'd0);

        // done_in high only during PULSE -> ignored, stays in WAIT
        bus_write(2'd2, 32'h3);
        done_in = 1'b1;
        bus_write(2'd0, 32'h1);
        count_pulse(hi);
        done_in = 1'b0;
        check_val("t7_pulse_len", hi, 3);
        repeat (5) @(negedge clk);
        read_chk("t7_no_done", 2'd1, 32'h21);
        bus_write(2'd0, 32'h4);
        read_chk("t7_abort", 2'd1, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
